paddle_mover: RTL and testbench

//  Parametrised movable paddle for the pong display path. Divides clk down to a movement tick,

---
 rtl/paddle_mover.sv | 159 +++++++++++++++
 tb/tb_paddle_mover.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_mover.sv
// paddle_mover: movable pong paddle. Provides a tick divider, clamped single-axis
// movement driven by active-low buttons, and a registered per-pixel draw flag.
// Optional build macro: PADDLE_ACCEL_EN. When it is defined, the step grows
// while a direction is held.
module paddle_mover #(
    parameter int TICK_DIV    = 125875,
    parameter int FIX_POS     = 460,
    parameter int THICK       = 10,
    parameter int LEN         = 50,
    parameter int MIN_POS     = 0,
    parameter int MAX_POS     = 585,
    parameter int INIT_POS    = 295,
    parameter int STEP        = 1,
    parameter int MAX_STEP    = 4,
    parameter int ACCEL_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] row,
    input  logic [9:0] column,
    input  logic       btn_dec_n,
    input  logic       btn_inc_n,
    input  logic       move_en,
    output logic       draw,
    output logic [9:0] pos,
    output logic       tick
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // Reject illegal configurations at elaboration time.
    if (TICK_DIV < 2 || STEP < 1 || MIN_POS > INIT_POS || INIT_POS > MAX_POS ||
        MAX_STEP < 1 || ACCEL_TICKS < 1) begin : g_bad_cfg
        $error("paddle_mover: illegal parameter configuration");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic [9:0]       pos_q, pos_d;
    logic             draw_q, draw_d;
    logic [10:0]      eff_step;
    logic             dec, inc, moving;

    assign dec    = ~btn_dec_n;
    assign inc    = ~btn_inc_n;
    assign moving = tick_q && move_en && (dec != inc);

`ifdef PADDLE_ACCEL_EN
    localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS + 1) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W:0]   hold_inc;
    logic [10:0]       step_q, step_d;
    logic              dir_q, dir_d;         // 1 = last run was toward MIN_POS
    logic              dir_vld_q, dir_vld_d;

    // Acceleration state: count held ticks and bump the step every ACCEL_TICKS.
    // A reversal moves by 1 in the reversal tick itself.
    always_comb begin
        hold_d    = hold_q;
        step_d    = step_q;
        dir_d     = dir_q;
        dir_vld_d = dir_vld_q;
        eff_step  = step_q;
        hold_inc  = {1'b0, hold_q} + 1'b1;
        if (tick_q) begin
            if (!moving) begin
                hold_d    = '0;
                step_d    = 11'd1;
                dir_vld_d = 1'b0;
            end else if (dir_vld_q && (dir_q != dec)) begin
                hold_d   = '0;
                step_d   = 11'd1;
                eff_step = 11'd1;
                dir_d    = dec;
            end else begin
                dir_d     = dec;
                dir_vld_d = 1'b1;
                if (hold_inc == (HOLD_W+1)'(ACCEL_TICKS)) begin
                    hold_d = '0;
                    if (step_q < 11'(MAX_STEP))
                        step_d = step_q + 11'd1;
                end else begin
                    hold_d = hold_inc[HOLD_W-1:0];
                end
            end
        end
    end

    // Acceleration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            step_q    <= 11'd1;
            dir_q     <= 1'b0;
            dir_vld_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            dir_vld_q <= dir_vld_d;
        end
    end
`else
    // Fixed step size.
    always_comb begin
        eff_step = 11'(STEP);
    end
`endif

    // Divider, clamped movement and draw-window compare.
    always_comb begin
        logic [10:0] pos_ext, col_ext, row_ext;
        pos_ext = {1'b0, pos_q};
        col_ext = {1'b0, column};
        row_ext = {1'b0, row};

        div_cnt_d = (div_cnt_q == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        tick_d    = (div_cnt_q == DIV_W'(TICK_DIV - 1));

        pos_d = pos_q;
        if (moving) begin
            if (dec) begin
                if (pos_ext < 11'(MIN_POS) + eff_step)
                    pos_d = 10'(MIN_POS);
                else
                    pos_d = 10'(pos_ext - eff_step);
            end else begin
                if (pos_ext + eff_step > 11'(MAX_POS))
                    pos_d = 10'(MAX_POS);
                else
                    pos_d = 10'(pos_ext + eff_step);
            end
        end

        draw_d = (row_ext >= 11'(FIX_POS)) && (row_ext < 11'(FIX_POS + THICK)) &&
                 (col_ext >= pos_ext) && (col_ext < pos_ext + 11'(LEN));
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            pos_q     <= 10'(INIT_POS);
            draw_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            pos_q     <= pos_d;
            draw_q    <= draw_d;
        end
    end

    assign draw = draw_q;
    assign pos  = pos_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_paddle_mover.sv
// tb_paddle_mover: directed self-checking bench for paddle_mover (TICK_DIV=4).
module tb_paddle_mover;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] row = '0;
    logic [9:0] column = '0;
    logic       btn_dec_n = 1'b1;
    logic       btn_inc_n = 1'b1;
    logic       move_en = 1'b1;
    logic       hi_inc_n = 1'b1;
    logic       lo_dec_n = 1'b1;

    logic       draw, tick, hi_draw, hi_tick, lo_draw, lo_tick;
    logic [9:0] pos, hi_pos, lo_pos;

    int errors = 0;
    int checks = 0;

`ifdef PADDLE_ACCEL_EN
    localparam int EXP_T2 = 319;   // steps 1,1,2,2,3,3,3,3,3,3
`else
    localparam int EXP_T2 = 305;
`endif

    always #5 clk = ~clk;

    paddle_mover #(.TICK_DIV(4), .MAX_STEP(3), .ACCEL_TICKS(2)) u_dut (
        .clk(clk), .rst(rst), .row(row), .column(column),
        .btn_dec_n(btn_dec_n), .btn_inc_n(btn_inc_n), .move_en(move_en),
        .draw(draw), .pos(pos), .tick(tick)
    );

    paddle_mover #(.TICK_DIV(4), .INIT_POS(583), .MAX_STEP(3), .ACCEL_TICKS(2)) u_hi (
        .clk(clk), .rst(rst), .row(row), .column(column),
        .btn_dec_n(1'b1), .btn_inc_n(hi_inc_n), .move_en(move_en),
        .draw(hi_draw), .pos(hi_pos), .tick(hi_tick)
    );

    paddle_mover #(.TICK_DIV(4), .INIT_POS(1), .MAX_STEP(3), .ACCEL_TICKS(2)) u_lo (
        .clk(clk), .rst(rst), .row(row), .column(column),
        .btn_dec_n(lo_dec_n), .btn_inc_n(1'b1), .move_en(move_en),
        .draw(lo_draw), .pos(lo_pos), .tick(lo_tick)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int cnt = 0;
        int guard = 0;
        while (cnt < n && guard < 200) begin
            cyc();
            if (tick) cnt++;
            guard++;
        end
        if (cnt < n) begin
            errors++; checks++;
            $display("FAIL tick_timeout: saw %0d ticks, required %0d", cnt, n);
        end
    endtask

    // Move off a tick cycle so new button levels apply to the next full tick.
    task automatic sync();
        if (tick) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        checks++; if (pos !== 10'd295) begin errors++; $display("FAIL reset_pos: got %0d, required 295", pos); end
        checks++; if (draw !== 1'b0) begin errors++; $display("FAIL reset_draw: got %b, required 0", draw); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, required 0", tick); end
        checks++; if (hi_pos !== 10'd583) begin errors++; $display("FAIL reset_hi_pos: got %0d, required 583", hi_pos); end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++;
            if (tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL tick_period k=%0d: got %b, required %b", k, tick, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_move();
        sync();
        btn_inc_n = 1'b0;
        move_en   = 1'b1;
        wait_ticks(10); cyc();
        checks++; if (pos !== 10'(EXP_T2)) begin errors++; $display("FAIL inc_10_ticks: got %0d, required %0d", pos, EXP_T2); end
        btn_dec_n = 1'b0;
        wait_ticks(5); cyc();
        checks++; if (pos !== 10'(EXP_T2)) begin errors++; $display("FAIL both_pressed_hold: got %0d, required %0d", pos, EXP_T2); end
        btn_dec_n = 1'b1;
        btn_inc_n = 1'b1;
    endtask

    task automatic test_clamp();
        sync();
        hi_inc_n = 1'b0;
        lo_dec_n = 1'b0;
        wait_ticks(1); cyc();
        checks++; if (hi_pos !== 10'd584) begin errors++; $display("FAIL clamp_hi_1: got %0d, required 584", hi_pos); end
        checks++; if (lo_pos !== 10'd0) begin errors++; $display("FAIL clamp_lo_1: got %0d, required 0", lo_pos); end
        wait_ticks(1); cyc();
        checks++; if (hi_pos !== 10'd585) begin errors++; $display("FAIL clamp_hi_2: got %0d, required 585", hi_pos); end
        checks++; if (lo_pos !== 10'd0) begin errors++; $display("FAIL clamp_lo_2: got %0d, required 0", lo_pos); end
        wait_ticks(1); cyc();
        checks++; if (hi_pos !== 10'd585) begin errors++; $display("FAIL clamp_hi_3: got %0d, required 585", hi_pos); end
        checks++; if (lo_pos !== 10'd0) begin errors++; $display("FAIL clamp_lo_3: got %0d, required 0", lo_pos); end
        hi_inc_n = 1'b1;
        lo_dec_n = 1'b1;
    endtask

    task automatic test_draw();
        logic [9:0] rv [6] = '{10'd460, 10'd460, 10'd470, 10'd459, 10'd469, 10'd460};
        logic [9:0] cv [6] = '{10'd295, 10'd345, 10'd300, 10'd300, 10'd344, 10'd294};
        logic       ev [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++; if (pos !== 10'd295) begin errors++; $display("FAIL draw_setup_pos: got %0d, required 295", pos); end
        row = 10'd0; column = 10'd0; cyc();
        row = rv[0]; column = cv[0]; #1;
        checks++; if (draw !== 1'b0) begin errors++; $display("FAIL draw_latency: got %b before edge, required 0", draw); end
        for (int i = 0; i < 6; i++) begin
            row = rv[i]; column = cv[i];
            cyc();
            checks++;
            if (draw !== ev[i]) begin
                errors++;
                $display("FAIL draw_vec%0d row=%0d col=%0d: got %b, required %b", i, rv[i], cv[i], draw, ev[i]);
            end
        end
        row = '0; column = '0;
    endtask

    task automatic test_reset_mid_move();
        sync();
        btn_inc_n = 1'b0;
        wait_ticks(2);           // first tick moved to 296, now in second tick cycle
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (pos !== 10'd295) begin errors++; $display("FAIL rst_on_tick_pos: got %0d, required 295", pos); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_on_tick_tick: got %b, required 0", tick); end
        cyc(); cyc(); cyc();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_div_early: got %b, required 0", tick); end
        cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL rst_div_restart: got %b, required 1", tick); end
        checks++; if (pos !== 10'd295) begin errors++; $display("FAIL rst_pos_before_move: got %0d, required 295", pos); end
        cyc();
        checks++; if (pos !== 10'd296) begin errors++; $display("FAIL rst_first_move: got %0d, required 296", pos); end
        move_en = 1'b0;
        wait_ticks(3); cyc();
        checks++; if (pos !== 10'd296) begin errors++; $display("FAIL move_en_off: got %0d, required 296", pos); end
        move_en   = 1'b1;
        btn_inc_n = 1'b1;
    endtask

`ifdef PADDLE_ACCEL_EN
    task automatic test_accel();
        int exp_seq [6] = '{296, 297, 299, 301, 304, 307};
        rst = 1'b1; cyc(); rst = 1'b0;
        btn_inc_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_ticks(1); cyc();
            checks++;
            if (pos !== 10'(exp_seq[i])) begin
                errors++;
                $display("FAIL accel_seq%0d: got %0d, required %0d", i, pos, exp_seq[i]);
            end
        end
        btn_inc_n = 1'b1;
        wait_ticks(1); cyc();
        btn_inc_n = 1'b0;
        wait_ticks(1); cyc();
        checks++; if (pos !== 10'd308) begin errors++; $display("FAIL accel_restart: got %0d, required 308", pos); end
        btn_inc_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_move();
        test_clamp();
        test_draw();
        test_reset_mid_move();
`ifdef PADDLE_ACCEL_EN
        test_accel();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
